// File: rtl/imm_gen_multi.sv
// imm_gen_multi: LANES-wide RISC-V immediate decoder feeding a DEPTH-entry output FIFO.
// Define IMMGEN_RVC_EN to decode compressed (16-bit) lanes; otherwise they report unknown.
`timescale 1ns/1ps
module imm_gen_multi #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned LANES = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [32*LANES-1:0]   in_insn,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN*LANES-1:0] out_imm,
   output logic [XLEN*LANES-1:0] out_jimm,
   output logic [LANES-1:0]      out_unknown
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [6:0] {
      OPC_LOAD      = 7'b0000011,
      OPC_OP_IMM    = 7'b0010011,
      OPC_AUIPC     = 7'b0010111,
      OPC_OP_IMM_32 = 7'b0011011,
      OPC_STORE     = 7'b0100011,
      OPC_LUI       = 7'b0110111,
      OPC_BRANCH    = 7'b1100011,
      OPC_JALR      = 7'b1100111,
      OPC_JAL       = 7'b1101111
   } opcode_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] jimm;
      logic            unk;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t            d;
      logic [XLEN-1:0] i_imm;
      logic [XLEN-1:0] sh;
      i_imm = XLEN'($signed(w[31:20]));
      sh    = (XLEN == 64) ? XLEN'(w[25:20]) : XLEN'(w[24:20]);
      d     = '0;
      if (w[1:0] == 2'b11) begin
         case (opcode_e'(w[6:0]))
            OPC_OP_IMM: begin
               d.imm  = (w[13:12] == 2'b01) ? sh : i_imm;
               d.jimm = i_imm;
            end
            OPC_OP_IMM_32: begin
               if (XLEN == 64) begin
                  d.imm  = (w[13:12] == 2'b01) ? XLEN'(w[24:20]) : i_imm;
                  d.jimm = i_imm;
               end else begin
                  d.unk = 1'b1;
               end
            end
            OPC_JAL: begin
               d.imm  = XLEN'(4);
               d.jimm = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            OPC_JALR: begin
               d.imm  = XLEN'(4);
               d.jimm = i_imm;
            end
            OPC_LOAD:  d.imm = i_imm;
            OPC_STORE: d.imm = XLEN'($signed({w[31:25], w[11:7]}));
            OPC_LUI, OPC_AUIPC: d.imm = XLEN'($signed({w[31:12], 12'b0}));
            OPC_BRANCH:
               d.jimm = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            default: d.unk = 1'b1;
         endcase
      end else begin
`ifdef IMMGEN_RVC_EN
         // Quadrant 01 only; funct3 001 is C.ADDIW on RV64, and LUI with rd=2 is C.ADDI16SP.
         if (w[1:0] == 2'b01) begin
            case (w[15:13])
               3'b000, 3'b010: d.imm = XLEN'($signed({w[12], w[6:2]}));
               3'b011: begin
                  if (w[11:7] != 5'd2) d.imm = XLEN'($signed({w[12], w[6:2], 12'b0}));
                  else                 d.unk = 1'b1;
               end
               3'b001, 3'b101: begin
                  if (w[15] || XLEN == 32)
                     d.jimm = XLEN'($signed({w[12], w[8], w[10:9], w[6], w[7], w[2],
                                             w[11], w[5:3], 1'b0}));
                  else
                     d.unk = 1'b1;
               end
               3'b110, 3'b111:
                  d.jimm = XLEN'($signed({w[12], w[6:5], w[2], w[11:10], w[4:3], 1'b0}));
               default: d.unk = 1'b1;
            endcase
         end else begin
            d.unk = 1'b1;
         end
`else
         d.unk = 1'b1;
`endif
      end
      return d;
   endfunction

   logic [XLEN*LANES-1:0] imm_q  [DEPTH];
   logic [XLEN*LANES-1:0] jimm_q [DEPTH];
   logic [LANES-1:0]      unk_q  [DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [XLEN*LANES-1:0] wr_imm, wr_jimm;
   logic [LANES-1:0]      wr_unk;
   dec_t                  lane;
   logic                  push, pop;

   always_comb begin
      wr_imm  = '0;
      wr_jimm = '0;
      wr_unk  = '0;
      lane    = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane = decode(in_insn[32*l +: 32]);
         wr_imm[XLEN*l +: XLEN]  = lane.imm;
         wr_jimm[XLEN*l +: XLEN] = lane.jimm;
         wr_unk[l]               = lane.unk;
      end
   end

   assign in_ready    = (cnt_q != CW'(DEPTH));
   assign out_valid   = (cnt_q != '0);
   assign out_imm     = imm_q[rptr_q];
   assign out_jimm    = jimm_q[rptr_q];
   assign out_unknown = unk_q[rptr_q];
   assign push        = in_valid & in_ready & ~flush;
   assign pop         = out_valid & out_ready & ~flush;

   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         cnt_d  = '0;
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            imm_q[i]  <= '0;
            jimm_q[i] <= '0;
            unk_q[i]  <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push) begin
            imm_q[wptr_q]  <= wr_imm;
            jimm_q[wptr_q] <= wr_jimm;
            unk_q[wptr_q]  <= wr_unk;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_multi.sv
// Bench for imm_gen_multi: vector tables, FIFO corner sequences, randomized scoreboard run.
`timescale 1ns/1ps
module tb_imm_gen_multi;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [63:0] a_in_insn, a_out_imm, a_out_jimm;
   logic [1:0]  a_out_unknown;
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_insn;
   logic [63:0] b_out_imm, b_out_jimm;
   logic [0:0]  b_out_unknown;

   imm_gen_multi #(.XLEN(32), .LANES(2), .DEPTH(2)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_insn(a_in_insn), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_imm(a_out_imm), .out_jimm(a_out_jimm), .out_unknown(a_out_unknown));

   imm_gen_multi #(.XLEN(64), .LANES(1), .DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_insn(b_in_insn), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_imm(b_out_imm), .out_jimm(b_out_jimm), .out_unknown(b_out_unknown));

   int unsigned n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct packed {
      logic [63:0] imm;
      logic [63:0] jimm;
      logic        unk;
   } res_t;

   // Reference decode: fields assembled with shifts/arithmetic straight from the ISA tables.
   function automatic res_t ref_dec(input logic [31:0] w, input int xlen);
      res_t   r;
      longint sw, iimm, simm, bimm, jo, uimm, sh, ci, cj, cb;
      sw   = longint'($signed(w));
      iimm = sw >>> 20;
      simm = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
      bimm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
             | (longint'(w[11:8]) << 1);
      jo   = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
             | (longint'(w[30:21]) << 1);
      uimm = sw & ~longint'(4095);
      sh   = longint'(w[25:20]) & longint'(xlen - 1);
      ci   = longint'({w[12], w[6:2]}) - (w[12] ? 64 : 0);
      cj   = (longint'(w[12]) << 11) | (longint'(w[11]) << 4) | (longint'(w[10:9]) << 8)
             | (longint'(w[8]) << 10) | (longint'(w[7]) << 6) | (longint'(w[6]) << 7)
             | (longint'(w[5:3]) << 1) | (longint'(w[2]) << 5);
      cj   = cj - (w[12] ? 4096 : 0);
      cb   = (longint'(w[12]) << 8) | (longint'(w[11:10]) << 3) | (longint'(w[6:5]) << 6)
             | (longint'(w[4:3]) << 1) | (longint'(w[2]) << 5);
      cb   = cb - (w[12] ? 512 : 0);
      r = '0;
      if (w[1:0] == 2'b11) begin
         case (w[6:0])
            7'h13: begin r.imm = (w[14:12] == 1 || w[14:12] == 5) ? sh : iimm; r.jimm = iimm; end
            7'h1B: begin
               if (xlen == 64) begin
                  r.imm  = (w[14:12] == 1 || w[14:12] == 5) ? longint'(w[24:20]) : iimm;
                  r.jimm = iimm;
               end else r.unk = 1'b1;
            end
            7'h6F: begin r.imm = 4; r.jimm = jo; end
            7'h67: begin r.imm = 4; r.jimm = iimm; end
            7'h03: r.imm = iimm;
            7'h23: r.imm = simm;
            7'h37, 7'h17: r.imm = uimm;
            7'h63: r.jimm = bimm;
            default: r.unk = 1'b1;
         endcase
      end else begin
`ifdef IMMGEN_RVC_EN
         if (w[1:0] == 2'b01) begin
            case (w[15:13])
               0, 2: r.imm = ci;
               3: if (w[11:7] != 2) r.imm = ci * 4096; else r.unk = 1'b1;
               5: r.jimm = cj;
               1: if (xlen == 32) r.jimm = cj; else r.unk = 1'b1;
               6, 7: r.jimm = cb;
               default: r.unk = 1'b1;
            endcase
         end else r.unk = 1'b1;
`else
         r.unk = 1'b1;
`endif
      end
      if (xlen == 32) begin
         r.imm  = {32'h0, r.imm[31:0]};
         r.jimm = {32'h0, r.jimm[31:0]};
      end
      return r;
   endfunction

   logic [6:0] OPS [12] = '{7'h13, 7'h1B, 7'h6F, 7'h67, 7'h03, 7'h23,
                            7'h37, 7'h17, 7'h63, 7'h33, 7'h73, 7'h0F};

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = OPS[$urandom_range(0, 11)];
      return w;
   endfunction

   typedef struct {
      logic [31:0] insn;
      logic [63:0] imm;
      logic [63:0] jimm;
      logic        unk;
   } vec_t;
   vec_t tv32[$], tv64[$];

   task automatic add32(input logic [31:0] i, input logic [31:0] im, input logic [31:0] jm,
                        input logic u);
      vec_t v;
      v.insn = i; v.imm = {32'h0, im}; v.jimm = {32'h0, jm}; v.unk = u;
      tv32.push_back(v);
   endtask

   task automatic add64(input logic [31:0] i, input logic [63:0] im, input logic [63:0] jm,
                        input logic u);
      vec_t v;
      v.insn = i; v.imm = im; v.jimm = jm; v.unk = u;
      tv64.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_insn = '0;
      b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_insn = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_a_head(input string name, input logic [63:0] beat);
      res_t r0, r1;
      r0 = ref_dec(beat[31:0], 32);
      r1 = ref_dec(beat[63:32], 32);
      chk({name, "_valid"}, a_out_valid, 1'b1);
      chk({name, "_imm"}, a_out_imm, {r1.imm[31:0], r0.imm[31:0]});
      chk({name, "_jimm"}, a_out_jimm, {r1.jimm[31:0], r0.jimm[31:0]});
      chk({name, "_unk"}, a_out_unknown, {r1.unk, r0.unk});
   endtask

   task automatic chk_b_head(input string name, input logic [31:0] insn);
      res_t r;
      r = ref_dec(insn, 64);
      chk({name, "_valid"}, b_out_valid, 1'b1);
      chk({name, "_imm"}, b_out_imm, r.imm);
      chk({name, "_jimm"}, b_out_jimm, r.jimm);
      chk({name, "_unk"}, b_out_unknown, r.unk);
   endtask

   task automatic run_rand_a(input int unsigned cycles);
      logic [63:0] q[$];
      logic        push, pop;
      for (int unsigned c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk("a_rand_in_ready", a_in_ready, q.size() != 2);
         chk("a_rand_out_valid", a_out_valid, q.size() != 0);
         if (q.size() != 0) chk_a_head("a_rand_head", q[0]);
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_insn   = {rand_insn(), rand_insn()};
         a_out_ready = ($urandom_range(0, 2) != 0);
         a_flush     = ($urandom_range(0, 31) == 0);
         push = a_in_valid && q.size() != 2;
         pop  = a_out_ready && q.size() != 0;
         if (a_flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(a_in_insn);
         end
      end
      @(negedge clk);
      a_in_valid = 0; a_out_ready = 0; a_flush = 0;
   endtask

   task automatic run_rand_b(input int unsigned cycles);
      logic [31:0] q[$];
      logic        push, pop;
      for (int unsigned c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk("b_rand_in_ready", b_in_ready, q.size() != 4);
         chk("b_rand_out_valid", b_out_valid, q.size() != 0);
         if (q.size() != 0) chk_b_head("b_rand_head", q[0]);
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_insn   = rand_insn();
         b_out_ready = ($urandom_range(0, 2) != 0);
         b_flush     = ($urandom_range(0, 31) == 0);
         push = b_in_valid && q.size() != 4;
         pop  = b_out_ready && q.size() != 0;
         if (b_flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b_in_insn);
         end
      end
      @(negedge clk);
      b_in_valid = 0; b_out_ready = 0; b_flush = 0;
   endtask

   localparam logic [63:0] BA = {32'h123450B7, 32'hFFF00093};
   localparam logic [63:0] BB = {32'hFE20AC23, 32'h008000EF};
   localparam logic [63:0] BC = {32'h00309093, 32'hFE000EE3};

   initial begin
      add32(32'hFFF00093, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);  // addi
      add32(32'h00309093, 32'h00000003, 32'h00000003, 0);  // slli 3
      add32(32'h123450B7, 32'h12345000, 32'h00000000, 0);  // lui
      add32(32'h008000EF, 32'h00000004, 32'h00000008, 0);  // jal +8
      add32(32'hFE000EE3, 32'h00000000, 32'hFFFFFFFC, 0);  // beq -4
      add32(32'hFE20AC23, 32'hFFFFFFF8, 32'h00000000, 0);  // sw -8
      add32(32'h00C08067, 32'h00000004, 32'h0000000C, 0);  // jalr 12
      add32(32'hFFC12083, 32'hFFFFFFFC, 32'h00000000, 0);  // lw -4
      add32(32'hFFFFF097, 32'hFFFFF000, 32'h00000000, 0);  // auipc
      add32(32'h40515093, 32'h00000005, 32'h00000405, 0);  // srai 5
      add32(32'h00209463, 32'h00000000, 32'h00000008, 0);  // bne +8
      add32(32'h002081B3, 32'h00000000, 32'h00000000, 1);  // add
      add32(32'h00000073, 32'h00000000, 32'h00000000, 1);  // ecall
      add32(32'h0010809B, 32'h00000000, 32'h00000000, 1);  // addiw not on RV32
      add64(32'h800000B7, 64'hFFFFFFFF80000000, 64'h0, 0);  // lui
      add64(32'h03F09093, 64'd63, 64'd63, 0);               // slli 63
      add64(32'hFFF0809B, '1, '1, 0);                       // addiw -1
      add64(32'h01F0909B, 64'd31, 64'd31, 0);               // slliw 31
      add64(32'h008000EF, 64'd4, 64'd8, 0);                 // jal
      add64(32'hFE000EE3, 64'h0, 64'hFFFFFFFFFFFFFFFC, 0);  // beq -4
`ifdef IMMGEN_RVC_EN
      add32(32'h000050FD, 32'hFFFFFFFF, 32'h0, 0);          // c.li -1
      add64(32'h000050FD, '1, 64'h0, 0);
`else
      add32(32'h000050FD, 32'h0, 32'h0, 1);
      add64(32'h000050FD, 64'h0, 64'h0, 1);
`endif

      do_reset();
      @(negedge clk);
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_ready", a_in_ready, 1);
      chk("rst_a_imm", a_out_imm, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_ready", b_in_ready, 1);
      chk("rst_b_jimm", b_out_jimm, 0);

      a_out_ready = 1;
      for (int i = 0; i < tv32.size(); i++) begin
         int j;
         j = (i + 1) % tv32.size();
         a_in_valid = 1; a_in_insn = {tv32[j].insn, tv32[i].insn};
         @(negedge clk);
         a_in_valid = 0;
         chk($sformatf("v32[%0d]_valid", i), a_out_valid, 1);
         chk($sformatf("v32[%0d]_imm", i), a_out_imm, {tv32[j].imm[31:0], tv32[i].imm[31:0]});
         chk($sformatf("v32[%0d]_jimm", i), a_out_jimm, {tv32[j].jimm[31:0], tv32[i].jimm[31:0]});
         chk($sformatf("v32[%0d]_unk", i), a_out_unknown, {tv32[j].unk, tv32[i].unk});
         @(negedge clk);
      end
      a_out_ready = 0;

      b_out_ready = 1;
      for (int i = 0; i < tv64.size(); i++) begin
         b_in_valid = 1; b_in_insn = tv64[i].insn;
         @(negedge clk);
         b_in_valid = 0;
         chk($sformatf("v64[%0d]_valid", i), b_out_valid, 1);
         chk($sformatf("v64[%0d]_imm", i), b_out_imm, tv64[i].imm);
         chk($sformatf("v64[%0d]_jimm", i), b_out_jimm, tv64[i].jimm);
         chk($sformatf("v64[%0d]_unk", i), b_out_unknown, tv64[i].unk);
         @(negedge clk);
      end
      b_out_ready = 0;

      // Back-pressure: A and B fill the FIFO, C waits, then all drain in order.
      do_reset();
      a_out_ready = 0; a_in_valid = 1; a_in_insn = BA;
      @(negedge clk);
      chk("bp_ready_after_A", a_in_ready, 1);
      a_in_insn = BB;
      @(negedge clk);
      chk("bp_ready_after_B", a_in_ready, 0);
      chk_a_head("bp_head_A", BA);
      a_in_insn = BC;
      @(negedge clk);
      chk("bp_C_held", a_in_ready, 0);
      chk_a_head("bp_head_stable", BA);
      a_out_ready = 1;
      @(negedge clk);
      chk("full_pop_only_ready", a_in_ready, 1);
      chk_a_head("bp_order_B", BB);
      @(negedge clk);
      chk_a_head("bp_order_C", BC);
      a_in_valid = 0;
      @(negedge clk);
      chk("bp_drained", a_out_valid, 0);
      a_out_ready = 0;

      // Flush with two beats buffered and a same-cycle push.
      b_in_valid = 1; b_in_insn = 32'h800000B7;
      @(negedge clk);
      b_in_insn = 32'h03F09093;
      @(negedge clk);
      chk("fl_two_ready", b_in_ready, 1);
      chk_b_head("fl_head_pre", 32'h800000B7);
      b_flush = 1; b_in_insn = 32'h008000EF;
      @(negedge clk);
      b_flush = 0; b_in_valid = 0;
      chk("fl_valid_cleared", b_out_valid, 0);
      chk("fl_ready", b_in_ready, 1);
      @(negedge clk);
      chk("fl_push_dropped", b_out_valid, 0);
      b_in_valid = 1; b_in_insn = 32'hFFF0809B;
      @(negedge clk);
      b_in_valid = 0;
      chk_b_head("fl_after_push", 32'hFFF0809B);

      // Reset mid-stream.
      a_in_valid = 1; a_in_insn = BA;
      @(negedge clk);
      a_in_insn = BB;
      @(negedge clk);
      a_in_valid = 0;
      chk("mid_full", a_in_ready, 0);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_rst_valid", a_out_valid, 0);
      chk("mid_rst_ready", a_in_ready, 1);
      chk("mid_rst_imm", a_out_imm, 0);
      chk("mid_rst_jimm", a_out_jimm, 0);
      chk("mid_rst_unk", a_out_unknown, 0);
      chk("mid_rst_b_valid", b_out_valid, 0);
      chk("mid_rst_b_imm", b_out_imm, 0);

      do_reset();
      run_rand_a(400);
      do_reset();
      run_rand_b(400);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/imm_gen_multi.md
# imm_gen_multi

Parametrised, multi-lane immediate generator for the decode stage, built as the successor to the single-lane generator. Accepts a beat of `LANES` instruction words over a valid/ready handshake and computes per-lane `imm` (ALU operand) and `jimm` (branch/jump offset) at `XLEN` width. Results pass through a `DEPTH`-entry output FIFO so that decode back-pressure never drops a beat. Sits between fetch/align and the register-read stage.

## Interface
- `XLEN`, 32: datapath width; 32 or 64.
- `LANES`, 1: instructions per beat; 1..4.
- `DEPTH`, 2: output FIFO entries; power of two, ≥2.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discards all buffered beats
- `in_valid`  in  1  beat offered
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_insn`  in  32*LANES  lane i at bits [32i+31:32i]
- `out_valid`  out  1  head beat available
- `out_ready`  in  1  head beat consumed when `out_valid & out_ready`
- `out_imm`  out  XLEN*LANES  per-lane operand immediate
- `out_jimm`  out  XLEN*LANES  per-lane control-flow offset
- `out_unknown`  out  LANES  lane opcode not recognised

## Operation
Lanes are decoded independently, combinationally at the input. The decoded result is written into the FIFO tail on accept.

**`imm` by opcode:**
- OP-IMM (0010011), funct3 1 or 5: zero-extended shamt, `imm[log2(XLEN)-1:0]`.
- OP-IMM, other funct3: sign-extended I-immediate.
- OP-IMM-32 (0011011, only when XLEN=64), funct3 1 or 5: zero-extended `imm[4:0]`.
- OP-IMM-32, other funct3: sign-extended I-immediate.
- JAL (1101111), JALR (1100111): constant 4.
- LOAD (0000011): sign-extended I-immediate.
- STORE (0100011): sign-extended S-immediate.
- LUI (0110111), AUIPC (0010111): `{imm[31:12], 12'b0}`, sign-extended to XLEN.
- Any other opcode: 0.

**`jimm` by opcode:**
- OP-IMM, OP-IMM-32, JALR: sign-extended I-immediate.
- BRANCH (1100011): sign-extended B-immediate with bit 0 = 0.
- JAL: sign-extended J-immediate with bit 0 = 0.
- Any other opcode: 0.

**`out_unknown[i]`:** set when lane i matches none of the opcodes above, and also for SYSTEM/OP/FENCE. Those are legal instructions with no immediate; `out_unknown` means "no immediate", not "illegal".

**FIFO:**
- Registered `count` in 0..DEPTH, with wrap-around read and write pointers.
- `in_ready = (count != DEPTH)`, driven from the register only. There is no combinational `out_ready`→`in_ready` path: a full FIFO refuses a push even in a cycle with a pop.
- Simultaneous push and pop with `0 < count < DEPTH`: count unchanged and both pointers advance.
- Pop when empty and push when full cannot occur (gated by `out_valid`/`in_ready`).
- `out_valid = (count != 0)`. `out_*` data is the head entry, read directly from storage.
- `flush`: count and pointers go to 0 next cycle. Flush overrides a same-cycle push (the beat is dropped) and a same-cycle pop.
- `rst`: count 0, pointers 0, storage cleared to 0. `out_valid` 0, `in_ready` 1, and `out_imm`, `out_jimm`, `out_unknown` all 0. Reset mid-stream discards all buffered beats.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid=1` after edge N (cycle N+1) if the FIFO was empty.
- Throughput: one beat per cycle while `out_ready=1`.
- `in_ready` falls the cycle after the DEPTH-th unconsumed push and rises the cycle after the first pop.
- Output data is stable while `out_valid & !out_ready`.

## Configuration
- `IMMGEN_RVC_EN` defined: a lane whose `insn[1:0] != 2'b11` is decoded as compressed, with only lane bits [15:0] used.
  - C.ADDI / C.LI → `imm` = sign-extended 6-bit CI immediate.
  - C.LUI → `imm` = sign-extended `{nzimm[17:12], 12'b0}`.
  - C.J / C.JAL → `jimm` = sign-extended CJ offset.
  - C.BEQZ / C.BNEZ → `jimm` = sign-extended CB offset.
  - Other compressed encodings → `out_unknown`.
- Not defined: any lane with `insn[1:0] != 2'b11` gives `imm = jimm = 0` and `out_unknown = 1`. The RVC decode logic is absent from the netlist.

## Test plan
- XLEN=32, LANES=1: `addi` 0xFFF00093 → imm 0xFFFFFFFF, jimm 0xFFFFFFFF. `slli` 0x00309093 → imm 3. `lui` 0x123450B7 → imm 0x12345000, jimm 0.
- XLEN=32, LANES=1: `jal` 0x008000EF → imm 4, jimm 8. `beq` 0xFE000EE3 → imm 0, jimm 0xFFFFFFFC. `sw` 0xFE20AC23 → imm 0xFFFFFFF8.
- LANES=2, DEPTH=2, `out_ready=0`: offer beats A, B, C on consecutive cycles → A and B accepted, `in_ready` 0 from the cycle after B, C held. Raise `out_ready` → A, B, C emerge in order, one per cycle.
- Full FIFO with `in_valid=1` and `out_ready=1` in the same cycle → pop only, count DEPTH-1. Push occurs on the following cycle.
- `flush` asserted with 2 beats buffered and a push in the same cycle → next cycle `out_valid=0`, count 0, pushed beat absent. `rst` mid-stream → all outputs 0 and `in_ready=1`.
- XLEN=64: `lui` 0x800000B7 → imm 0xFFFFFFFF80000000. `slli` shamt 63 (0x03F09093) → imm 63. With `IMMGEN_RVC_EN`, `c.li` 0x50FD → imm all-ones. Without it → imm 0 and `out_unknown=1`.
